// File: rtl/icache_pkg.sv
// Shared constants and state type for the instruction-cache refill path.
// A line is 16 bytes fetched as two 64-bit beats; the tag starts at bit 10.
package icache_pkg;

    localparam int LINE_OFF_BITS = 4;
    localparam int WORD_OFF_BITS = 3;
    localparam int IDX_HI        = 9;
    localparam int TAG_LO        = 10;

    localparam int LINE_BYTES = 1 << LINE_OFF_BITS;
    localparam int BEAT_BYTES = 1 << WORD_OFF_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WR0,
        S_WR1,
        S_DONE,
        S_ERR
    } refill_state_t;

endpackage

// File: rtl/icache_refill_ctl.sv
// I-cache miss handler: fetches a 16-byte line as two beats, buffers it, and
// writes the whole line into the cache only if both beats arrived without error.
module icache_refill_ctl
    import icache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BEATS  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_miss_if,
    input  logic [ADDR_W-1:0] ic_addr_if,
    input  logic              kill,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_rerr,
    output logic              ic_write_ff,
    output logic [ADDR_W-1:0] ic_write_addr_ff,
    output logic [63:0]       ic_write_data_ff,
    output logic              refill_busy,
    output logic              refill_done,
    output logic              refill_err
);

    localparam int LINE_W = ADDR_W - LINE_OFF_BITS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    refill_state_t     state_reg, state_next;
    logic [LINE_W-1:0] line_reg;
    logic [BEAT_W-1:0] cnt_reg;
    logic              err_reg;
    logic              kill_reg;
    logic [63:0]       beat_buf [BEATS];

    logic unused_ok;
    assign unused_ok = ^ic_addr_if[LINE_OFF_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            line_reg  <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            kill_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (ic_miss_if) begin
                        line_reg <= ic_addr_if[ADDR_W-1:LINE_OFF_BITS];
                        cnt_reg  <= '0;
                        err_reg  <= 1'b0;
                        kill_reg <= 1'b0;
                    end
                end
                S_REQ: begin
                    // A beat may ride along with the grant; it is beat 0.
                    if (mem_gnt && mem_rvalid) begin
                        beat_buf[0] <= mem_rdata;
                        cnt_reg     <= BEAT_W'(1);
                        err_reg     <= err_reg | mem_rerr;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        beat_buf[cnt_reg] <= mem_rdata;
                        cnt_reg           <= cnt_reg + 1'b1;
                        err_reg           <= err_reg | mem_rerr;
                    end
                end
                default: ;
            endcase
            if (state_reg != S_IDLE && kill)
                kill_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next       = state_reg;
        mem_req          = 1'b0;
        mem_addr         = '0;
        ic_write_ff      = 1'b0;
        ic_write_addr_ff = '0;
        ic_write_data_ff = '0;
        refill_busy      = (state_reg != S_IDLE);
        refill_done      = 1'b0;
        refill_err       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (ic_miss_if)
                    state_next = S_REQ;
            end
            S_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {line_reg, {LINE_OFF_BITS{1'b0}}};
                if (mem_gnt)
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid && cnt_reg == LAST_BEAT)
                    state_next = (err_reg || mem_rerr) ? S_ERR : S_WR0;
            end
            S_WR0: begin
                ic_write_ff      = 1'b1;
                ic_write_addr_ff = {line_reg, 1'b0, {WORD_OFF_BITS{1'b0}}};
                ic_write_data_ff = beat_buf[0];
                state_next       = S_WR1;
            end
            S_WR1: begin
                ic_write_ff      = 1'b1;
                ic_write_addr_ff = {line_reg, 1'b1, {WORD_OFF_BITS{1'b0}}};
                ic_write_data_ff = beat_buf[1];
                state_next       = S_DONE;
            end
            S_DONE: begin
                refill_done = !kill_reg;
                state_next  = S_IDLE;
            end
            S_ERR: begin
                refill_err = !kill_reg;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    rvalid_protocol: assert property (@(posedge clk) disable iff (reset)
        mem_rvalid |-> (state_reg == S_WAIT || (state_reg == S_REQ && mem_gnt)));

endmodule

// File: tb/tb_icache_refill_ctl.sv
// Randomized bench for icache_refill_ctl: each refill is scheduled as a timeline
// of edges, and expected outputs per cycle are derived from that timeline.
module tb_icache_refill_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_miss_if;
    logic [31:0] ic_addr_if;
    logic        kill;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_rerr;
    logic        ic_write_ff;
    logic [31:0] ic_write_addr_ff;
    logic [63:0] ic_write_data_ff;
    logic        refill_busy;
    logic        refill_done;
    logic        refill_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icache_refill_ctl #(.ADDR_W(32), .BEATS(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .ic_miss_if       (ic_miss_if),
        .ic_addr_if       (ic_addr_if),
        .kill             (kill),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .mem_rerr         (mem_rerr),
        .ic_write_ff      (ic_write_ff),
        .ic_write_addr_ff (ic_write_addr_ff),
        .ic_write_data_ff (ic_write_data_ff),
        .refill_busy      (refill_busy),
        .refill_done      (refill_done),
        .refill_err       (refill_err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ic_miss_if = 1'b0;
        ic_addr_if = '0;
        kill       = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_rerr   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req"},   mem_req,          0);
        check_val({tag, "_maddr"}, mem_addr,         0);
        check_val({tag, "_wr"},    ic_write_ff,      0);
        check_val({tag, "_waddr"}, ic_write_addr_ff, 0);
        check_val({tag, "_wdata"}, ic_write_data_ff, 0);
        check_val({tag, "_busy"},  refill_busy,      0);
        check_val({tag, "_done"},  refill_done,      0);
        check_val({tag, "_err"},   refill_err,       0);
    endtask

    // Edge 0 is the miss. Grant at edge g, beat 0 at b0 (>= g), beat 1 at m.
    // Outputs observed in cycle e are those after edge e.
    task automatic run_refill(input logic [31:0] addr, input int gd, input int b0d, input int b1d,
                              input bit e0, input bit e1, input int kill_e, input int xm_e,
                              input logic [63:0] d0, input logic [63:0] d1);
        int g, b0, m, last, n_wr, n_done, n_err;
        bit good, killed;
        logic [31:0] base;
        base   = {addr[31:4], 4'h0};
        g      = 1 + gd;
        b0     = g + b0d;
        m      = b0 + 1 + b1d;
        good   = !(e0 || e1);
        killed = (kill_e >= 1) && (kill_e <= (good ? m + 2 : m));
        last   = good ? m + 3 : m + 1;
        n_wr = 0; n_done = 0; n_err = 0;
        for (int e = 0; e <= last; e++) begin
            ic_miss_if = (e == 0) || (e == xm_e);
            ic_addr_if = (e == 0) ? addr : $urandom;
            mem_gnt    = (e == g);
            mem_rvalid = (e == b0) || (e == m);
            mem_rdata  = (e == b0) ? d0 : ((e == m) ? d1 : 64'h0);
            mem_rerr   = ((e == b0) && e0) || ((e == m) && e1);
            kill       = (e == kill_e);
            @(posedge clk);
            @(negedge clk);
            check_val("busy", refill_busy, e < last);
            check_val("req", mem_req, e < g);
            if (e < g) check_val("mem_addr", mem_addr, base);
            check_val("wr", ic_write_ff, good && (e == m || e == m + 1));
            if (good && e == m) begin
                check_val("wr0_addr", ic_write_addr_ff, base);
                check_val("wr0_data", ic_write_data_ff, d0);
            end
            if (good && e == m + 1) begin
                check_val("wr1_addr", ic_write_addr_ff, base | 32'h8);
                check_val("wr1_data", ic_write_data_ff, d1);
            end
            check_val("done", refill_done, good && !killed && e == m + 2);
            check_val("err", refill_err, !good && !killed && e == m);
            n_wr   += ic_write_ff;
            n_done += refill_done;
            n_err  += refill_err;
        end
        idle_inputs();
        $display("refill addr=%08h gd=%0d b0d=%0d b1d=%0d rerr=%0b%0b kill@%0d xmiss@%0d writes=%0d done=%0d err=%0d",
                 addr, gd, b0d, b1d, e0, e1, kill_e, xm_e, n_wr, n_done, n_err);
    endtask

    initial begin
        int gd, b0d, b1d, m, last, ke, xe;
        bit e0, e1;
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("idle");

        // Directed scenarios.
        run_refill(32'h0000_1234, 0, 1, 0, 0, 0, -1, -1, 64'hA0A0_A0A0_A0A0_A0A0, 64'hB1B1_B1B1_B1B1_B1B1);
        run_refill(32'h0000_2010, 4, 3, 2, 0, 0, -1, -1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        run_refill(32'h0000_4440, 1, 1, 1, 1, 0, -1, -1, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0002);
        run_refill(32'h0000_3FF8, 0, 2, 1, 0, 0, 3, -1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        run_refill(32'h0000_7000, 0, 0, 0, 0, 0, -1, 2, 64'hCAFE_0000_0000_0000, 64'h0000_0000_0000_CAFE);
        run_refill(32'h0000_8800, 2, 0, 3, 0, 0, 0, -1, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0);
        run_refill(32'h0000_9900, 0, 1, 0, 0, 1, 2, -1, 64'h1, 64'h2);

        // Reset in the middle of WAIT, then a normal refill.
        ic_miss_if = 1'b1;
        ic_addr_if = 32'h0000_5550;
        @(posedge clk); @(negedge clk);
        ic_miss_if = 1'b0;
        mem_gnt    = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_gnt = 1'b0;
        check_val("rst_busy_before", refill_busy, 1);
        check_val("rst_req_before", mem_req, 0);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check_all_zero("rst_mid");
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        check_all_zero("rst_after");
        $display("reset mid-WAIT addr=00005550 busy=%0b", refill_busy);
        run_refill(32'h0000_5550, 0, 1, 1, 0, 0, -1, -1, 64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5);

        // Randomized refills.
        for (int i = 0; i < 60; i++) begin
            gd   = $urandom_range(0, 5);
            b0d  = $urandom_range(0, 3);
            b1d  = $urandom_range(0, 3);
            e0   = ($urandom_range(0, 9) == 0);
            e1   = ($urandom_range(0, 9) == 0);
            m    = 1 + gd + b0d + 1 + b1d;
            last = (e0 || e1) ? m + 1 : m + 3;
            ke   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, last)) : -1;
            xe   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, last)) : -1;
            run_refill($urandom, gd, b0d, b1d, e0, e1, ke, xe,
                       {$urandom, $urandom}, {$urandom, $urandom});
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); @(negedge clk);
                check_val("gap_busy", refill_busy, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
